mdu: RTL and testbench
======================

Name: mdu

Overview:
- Iterative multiply/divide unit placed directly upstream of the accumulator.
- Captures two operands: A from the accumulator output and B from the memory/operand bus.
- Runs a bit-serial shift-add multiply or restoring divide, then presents the result on mdu_out with a one-cycle mdu_done pulse that drives the accumulator write enable.
- Lets the accumulator-based datapath execute MUL/DIV/REM without a combinational array.

Parameters:
- WIDTH, 11, operand and result width in bits (matches the accumulator width).

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- mdu_reset_n  input  1  asynchronous, active-low reset.
- mdu_start  input  1  request a new operation; sampled on the rising edge.
- mdu_op  input  2  operation: 00 MUL (low word), 01 DIV (quotient), 10 REM (remainder), 11 MULH (high word).
- mdu_a  input  WIDTH  multiplicand / dividend (unsigned).
- mdu_b  input  WIDTH  multiplier / divisor (unsigned).
- mdu_out  output  WIDTH  registered result; feeds acc_in.
- mdu_done  output  1  one-cycle pulse when mdu_out is updated; feeds acc_wr.
- mdu_busy  output  1  high while an operation is iterating.
- mdu_ovf  output  1  MUL/MULH only: full product exceeds WIDTH bits.
- mdu_dz  output  1  DIV/REM only: divisor was zero.

Behaviour:
- One clock domain; reset is asynchronous and active-low.
- Reset (mdu_reset_n=0, any time, including mid-operation):
  - state goes to IDLE; counter and working registers clear.
  - mdu_out=0, mdu_done=0, mdu_busy=0, mdu_ovf=0, mdu_dz=0.
  - any operation in flight is abandoned, with no done pulse after release.
- States:
  - IDLE: waiting.
  - RUN: iterating; counter counts 0..WIDTH-1.
  - DONE: result presented for one cycle.
- Transitions:
  - IDLE --start--> RUN.
  - RUN --(counter==WIDTH-1)--> DONE.
  - DONE --start--> RUN.
  - DONE --no start--> IDLE.
- Accept rule:
  - mdu_start is accepted only in IDLE or DONE.
  - At the accepting edge E0: mdu_a, mdu_b and mdu_op are latched into internal registers.
  - Input changes after E0 have no effect on the running operation.
  - mdu_start during RUN is ignored; it is not queued.
- Latency:
  - One iteration at each edge E1..E_WIDTH.
  - At E_WIDTH: mdu_out and flags load, state goes to DONE.
  - mdu_done=1 for exactly the cycle between E_WIDTH and E_WIDTH+1.
  - mdu_busy=1 from E0 until E_WIDTH (state RUN only).
  - Back-to-back: start in DONE gives a new E0 at E_WIDTH+1, i.e. WIDTH+1 cycles per operation.
- Multiply (MUL/MULH):
  - Unsigned shift-add into a 2*WIDTH product register.
  - MUL returns product[WIDTH-1:0]; MULH returns product[2*WIDTH-1:WIDTH].
  - mdu_ovf = (product[2*WIDTH-1:WIDTH] != 0) for both ops.
  - mdu_dz=0.
- Divide (DIV/REM):
  - Unsigned restoring division: WIDTH+1-bit partial remainder, one quotient bit per iteration, MSB first.
  - DIV returns the quotient; REM returns the remainder.
  - mdu_ovf=0.
- Divide by zero (mdu_b=0 at E0):
  - No special path; same latency.
  - Quotient = all ones (2^WIDTH-1), remainder = dividend.
  - mdu_dz=1.
- Output hold: mdu_out, mdu_ovf and mdu_dz hold their values until the next result load or reset. They are not cleared at start.
- Edge operands:
  - A=0 or B=0 on multiply gives 0 with ovf=0.
  - A<B on divide gives quotient 0, remainder A.
  - A=B=2^WIDTH-1 on MUL gives out=1, MULH gives 2046, ovf=1.

Test Plan:
- Reset: hold mdu_reset_n=0 and toggle start/op -> all outputs 0, busy never rises. Release, then start MUL 50*25 -> at E11 out=1250, ovf=0, done high exactly one cycle, busy high E0..E11.
- Overflow: MUL 1426*3 -> out=182, ovf=1. Repeat with op=11 (MULH) -> out=2, ovf=1.
- Division: DIV 1426/50 -> out=28, dz=0. REM 1426/50 -> out=26. DIV 20/50 -> out=0. REM 20/50 -> out=20.
- Divide by zero: DIV 1795/0 -> out=2047, dz=1, done at E11. REM 1795/0 -> out=1795, dz=1.
- Ignored start and operand stability:
  - During RUN of DIV 1426/50, pulse start with op=MUL, a=7, b=7 and change mdu_a/mdu_b every cycle -> result still 28, one done pulse only.
  - Start asserted in the DONE cycle -> new op accepted; next done exactly 12 cycles after the previous one.
- Reset mid-operation: drop mdu_reset_n asynchronously (between edges) at E5 of MUL 1426*3 -> outputs 0 immediately. After release: no done pulse, busy=0, state IDLE; the next MUL 50*25 completes normally with out=1250.

Source files
------------

// File: rtl/mdu_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mdu_if: start/operand/result bundle between sequencer and mdu. Rev 1.0 |
// +----------------------------------------------------------------------+
interface mdu_if #(
  parameter int WIDTH = 11
);
  logic             mdu_start;
  logic [1:0]       mdu_op;
  logic [WIDTH-1:0] mdu_a;
  logic [WIDTH-1:0] mdu_b;
  logic [WIDTH-1:0] mdu_out;
  logic             mdu_done;
  logic             mdu_busy;
  logic             mdu_ovf;
  logic             mdu_dz;

  modport master (
    output mdu_start, mdu_op, mdu_a, mdu_b,
    input  mdu_out, mdu_done, mdu_busy, mdu_ovf, mdu_dz
  );

  modport slave (
    input  mdu_start, mdu_op, mdu_a, mdu_b,
    output mdu_out, mdu_done, mdu_busy, mdu_ovf, mdu_dz
  );
endinterface
`default_nettype wire

// File: rtl/mdu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mdu: bit-serial shift-add multiplier / restoring divider.    Rev 1.0 |
// +----------------------------------------------------------------------+
module mdu #(
  parameter int WIDTH = 11
) (
  input  wire logic clock,
  input  wire logic mdu_reset_n,
  mdu_if.slave      bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_MULH = 2'b11;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             ovf_q, ovf_d;
  logic             dz_q, dz_d;

  logic             is_mul;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_rem;
  logic             div_ge;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;

  // hi:lo is the product register for multiply, and remainder:dividend/quotient for divide
  always_comb begin
    is_mul    = (op_q == OP_MUL) || (op_q == OP_MULH);
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, b_q});
    div_rem   = div_shift[WIDTH-1:0] - b_q;
    if (is_mul) begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    end else begin
      step_hi = div_ge ? div_rem : div_shift[WIDTH-1:0];
      step_lo = {lo_q[WIDTH-2:0], div_ge};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    out_d   = out_q;
    ovf_d   = ovf_q;
    dz_d    = dz_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.mdu_start) begin
          state_d = S_RUN;
          cnt_d   = '0;
          op_d    = bus.mdu_op;
          b_d     = bus.mdu_b;
          hi_d    = '0;
          lo_d    = bus.mdu_a;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = S_DONE;
          cnt_d   = '0;
          case (op_q)
            OP_MUL, OP_DIV:  out_d = step_lo;
            OP_REM, OP_MULH: out_d = step_hi;
            default:         out_d = step_lo;
          endcase
          ovf_d = is_mul && (step_hi != '0);
          dz_d  = !is_mul && (b_q == '0);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge mdu_reset_n) begin
    if (!mdu_reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      out_q   <= '0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      out_q   <= out_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
    end
  end

  assign bus.mdu_out  = out_q;
  assign bus.mdu_done = (state_q == S_DONE);
  assign bus.mdu_busy = (state_q == S_RUN);
  assign bus.mdu_ovf  = ovf_q;
  assign bus.mdu_dz   = dz_q;
endmodule
`default_nettype wire

// File: tb/tb_mdu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mdu: vector table, directed corner sequences, random vs model.    |
// +----------------------------------------------------------------------+
module tb_mdu;
  localparam int W = 11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  mdu_if #(.WIDTH(W)) bus ();

  mdu #(.WIDTH(W)) dut (
    .clock       (clk),
    .mdu_reset_n (rst_n),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    int         a;
    int         b;
    int         out;
    logic       ovf;
    logic       dz;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the unsigned operands
  function automatic void ref_model(input logic [1:0] op, input int a, input int b,
                                    output int out, output logic ovf, output logic dz);
    longint p;
    p   = longint'(a) * longint'(b);
    ovf = 1'b0;
    dz  = 1'b0;
    case (op)
      2'b00: begin out = int'(p % (1 << W)); ovf = (p >= (1 << W)); end
      2'b11: begin out = int'(p / (1 << W)); ovf = (p >= (1 << W)); end
      2'b01: begin out = (b == 0) ? ((1 << W) - 1) : a / b; dz = (b == 0); end
      default: begin out = (b == 0) ? a : a % b; dz = (b == 0); end
    endcase
  endfunction

  task automatic wait_done(output int n);
    n = 0;
    while (bus.mdu_done !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic do_op(input logic [1:0] op, input int a, input int b,
                       output logic [W-1:0] out, output logic ovf, output logic dz);
    int lat;
    int busy_err;
    @(negedge clk);
    bus.mdu_op    = op;
    bus.mdu_a     = a[W-1:0];
    bus.mdu_b     = b[W-1:0];
    bus.mdu_start = 1'b1;
    @(posedge clk); #1;
    bus.mdu_start = 1'b0;
    lat = 0;
    busy_err = 0;
    while (bus.mdu_done !== 1'b1 && lat < 40) begin
      if (bus.mdu_busy !== 1'b1) busy_err++;
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, W);
    check("busy_during_run", busy_err, 0);
    check("busy_at_done", bus.mdu_busy, 0);
    out = bus.mdu_out;
    ovf = bus.mdu_ovf;
    dz  = bus.mdu_dz;
    @(posedge clk); #1;
    check("done_one_cycle", bus.mdu_done, 0);
    check("out_hold", bus.mdu_out, out);
  endtask

  initial begin
    logic [W-1:0] r_out;
    logic         r_ovf, r_dz;
    int           e_out;
    logic         e_ovf, e_dz;
    int           n, dones, busy_seen;
    logic [W-1:0] prev;

    vecs.push_back('{2'b00,   50,   25, 1250, 1'b0, 1'b0});
    vecs.push_back('{2'b00, 1426,    3,  182, 1'b1, 1'b0});
    vecs.push_back('{2'b11, 1426,    3,    2, 1'b1, 1'b0});
    vecs.push_back('{2'b01, 1426,   50,   28, 1'b0, 1'b0});
    vecs.push_back('{2'b10, 1426,   50,   26, 1'b0, 1'b0});
    vecs.push_back('{2'b01,   20,   50,    0, 1'b0, 1'b0});
    vecs.push_back('{2'b10,   20,   50,   20, 1'b0, 1'b0});
    vecs.push_back('{2'b01, 1795,    0, 2047, 1'b0, 1'b1});
    vecs.push_back('{2'b10, 1795,    0, 1795, 1'b0, 1'b1});
    vecs.push_back('{2'b00, 2047, 2047,    1, 1'b1, 1'b0});
    vecs.push_back('{2'b11, 2047, 2047, 2046, 1'b1, 1'b0});
    vecs.push_back('{2'b00,    0, 1234,    0, 1'b0, 1'b0});
    vecs.push_back('{2'b11, 1234,    0,    0, 1'b0, 1'b0});
    vecs.push_back('{2'b01, 2047,    1, 2047, 1'b0, 1'b0});

    bus.mdu_start = 1'b0;
    bus.mdu_op    = 2'b00;
    bus.mdu_a     = '0;
    bus.mdu_b     = '0;

    // Held in reset while start/op toggle: everything stays at zero
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.mdu_start = ~bus.mdu_start;
      bus.mdu_op    = 2'(i);
      bus.mdu_a     = 11'd50;
      bus.mdu_b     = 11'd25;
      @(posedge clk); #1;
      check("reset_outputs", {bus.mdu_out, bus.mdu_done, bus.mdu_busy, bus.mdu_ovf, bus.mdu_dz}, 0);
    end
    @(negedge clk);
    bus.mdu_start = 1'b0;
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, r_out, r_ovf, r_dz);
      check($sformatf("vec%0d_out", i), r_out, vecs[i].out);
      check($sformatf("vec%0d_ovf", i), r_ovf, vecs[i].ovf);
      check($sformatf("vec%0d_dz", i), r_dz, vecs[i].dz);
    end
    prev = bus.mdu_out;

    // Ignored start and changing operands while a divide runs
    @(negedge clk);
    bus.mdu_op = 2'b01; bus.mdu_a = 11'd1426; bus.mdu_b = 11'd50; bus.mdu_start = 1'b1;
    @(posedge clk); #1;
    bus.mdu_start = 1'b0;
    check("out_not_cleared_at_start", bus.mdu_out, prev);
    dones = 0;
    r_out = '0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      bus.mdu_start = (i < 8) ? 1'b1 : 1'b0;
      bus.mdu_op    = 2'b00;
      bus.mdu_a     = (i < 4) ? 11'd7 : 11'($urandom);
      bus.mdu_b     = (i < 4) ? 11'd7 : 11'($urandom);
      @(posedge clk); #1;
      if (bus.mdu_done === 1'b1) begin
        dones++;
        r_out = bus.mdu_out;
      end
    end
    bus.mdu_start = 1'b0;
    check("ignored_start_done_count", dones, 1);
    check("ignored_start_out", r_out, 28);

    // Back-to-back: start during the DONE cycle
    @(negedge clk);
    bus.mdu_op = 2'b01; bus.mdu_a = 11'd1426; bus.mdu_b = 11'd50; bus.mdu_start = 1'b1;
    @(posedge clk); #1;
    bus.mdu_start = 1'b0;
    wait_done(n);
    check("b2b_first_latency", n, W);
    @(negedge clk);
    bus.mdu_op = 2'b00; bus.mdu_a = 11'd50; bus.mdu_b = 11'd25; bus.mdu_start = 1'b1;
    @(posedge clk); #1;
    bus.mdu_start = 1'b0;
    check("b2b_accepted", bus.mdu_busy, 1);
    wait_done(n);
    check("b2b_done_gap", n + 1, 12);
    check("b2b_out", bus.mdu_out, 1250);

    // Asynchronous reset in the middle of a multiply
    do_op(2'b00, 1426, 3, r_out, r_ovf, r_dz);
    check("pre_reset_out", r_out, 182);
    @(negedge clk);
    bus.mdu_op = 2'b00; bus.mdu_a = 11'd1426; bus.mdu_b = 11'd3; bus.mdu_start = 1'b1;
    @(posedge clk); #1;
    bus.mdu_start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midreset_outputs", {bus.mdu_out, bus.mdu_done, bus.mdu_busy, bus.mdu_ovf, bus.mdu_dz}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    busy_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.mdu_done === 1'b1) dones++;
      if (bus.mdu_busy === 1'b1) busy_seen++;
    end
    check("midreset_no_done", dones, 0);
    check("midreset_no_busy", busy_seen, 0);
    do_op(2'b00, 50, 25, r_out, r_ovf, r_dz);
    check("after_reset_out", r_out, 1250);
    check("after_reset_ovf", r_ovf, 0);

    // Random operations against the arithmetic model
    for (int i = 0; i < 60; i++) begin
      logic [1:0] op;
      int a, b;
      op = 2'($urandom_range(0, 3));
      a  = int'($urandom_range(0, (1 << W) - 1));
      case ($urandom_range(0, 7))
        0:       b = 0;
        1:       b = int'($urandom_range(1, 15));
        default: b = int'($urandom_range(0, (1 << W) - 1));
      endcase
      ref_model(op, a, b, e_out, e_ovf, e_dz);
      do_op(op, a, b, r_out, r_ovf, r_dz);
      check($sformatf("rand op=%0d a=%0d b=%0d out", op, a, b), r_out, e_out);
      check($sformatf("rand op=%0d a=%0d b=%0d ovf", op, a, b), r_ovf, e_ovf);
      check($sformatf("rand op=%0d a=%0d b=%0d dz", op, a, b), r_dz, e_dz);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
`default_nettype wire
